// File: rtl/mbt_pkg.sv
// Shared types and helpers for the memory BIST tester.
//  - state_t  : tester FSM states
//  - PAT_*    : pattern codes understood by mbt_pattern_gen
//  - pick_pat : lowest set bit of a pattern mask at or above a start index
package mbt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned PW = 2;

    localparam logic [PW-1:0] PAT_ZERO  = 2'd0;
    localparam logic [PW-1:0] PAT_ONES  = 2'd1;
    localparam logic [PW-1:0] PAT_CHECK = 2'd2;
    localparam logic [PW-1:0] PAT_ADDR  = 2'd3;

    // Returns {found, index}; scanning downwards leaves the lowest qualifying bit.
    function automatic logic [2:0] pick_pat(input logic [3:0] mask, input logic [2:0] lo);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= lo)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/mbt_pattern_gen.sv
// Combinational expected-data generator for the memory BIST tester.
// Ports:
//  pat      in  2   pattern code (PAT_ZERO/ONES/CHECK/ADDR)
//  addr     in  AW  word address
//  expected out DW  data that pattern pat places at addr
module mbt_pattern_gen
    import mbt_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic [PW-1:0] pat,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] expected
);

    // Checkerboard: bit 0 is 1 at even addresses; address pattern repeats addr bits.
    always_comb begin
        expected = '0;
        for (int i = 0; i < DW; i++) begin
            case (pat)
                PAT_ZERO:  expected[i] = 1'b0;
                PAT_ONES:  expected[i] = 1'b1;
                PAT_CHECK: expected[i] = addr[0] ^ (i % 2 == 0);
                default:   expected[i] = addr[i % AW];
            endcase
        end
    end

endmodule

// File: rtl/mem_bist_tester.sv
// Parametrised BIST tester for a synchronous 1R1W memory with 1-cycle read.
// Each enabled pattern runs a write pass, a read-verify pass and a drain cycle.
// Optional feature macro: MBT_FIRST_FAIL_EN (first-fail capture on ff_*).
// Ports:
//  clock, reset(async active-low), enable(stall when 0), start, abort, pat_mask
//  we/wra/wrd  : memory write port        rda/rdd : memory read port
//  busy/done/pass : run status            attempts/fails : per-pattern counts
//  ff_valid/ff_pat/ff_addr/ff_data : first-fail record (0 when feature off)
module mem_bist_tester
    import mbt_pkg::*;
#(
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned NPAT = 4,
    parameter int unsigned CW   = AW + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NPAT-1:0]      pat_mask,
    output logic                 we,
    output logic [AW-1:0]        wra,
    output logic [DW-1:0]        wrd,
    output logic [AW-1:0]        rda,
    input  logic [DW-1:0]        rdd,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NPAT*CW-1:0]   attempts,
    output logic [NPAT*CW-1:0]   fails,
    output logic                 ff_valid,
    output logic [PW-1:0]        ff_pat,
    output logic [AW-1:0]        ff_addr,
    output logic [DW-1:0]        ff_data
);

    state_t          state, state_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic [PW-1:0]   pat, pat_nxt;
    logic [DW-1:0]   expected_c, exp_q;
    logic            cmp_pending, any_fail;
    logic            clear_c, empty_c, wr_c, rd_c, finish_c, cmp_c, miss_c;
    logic [2:0]      first_c, next_c;

    mbt_pattern_gen #(.AW(AW), .DW(DW)) u_gen (
        .pat      (pat),
        .addr     (addr),
        .expected (expected_c)
    );

    // The address counter is presented directly so the memory samples it on the issuing edge.
    assign rda = addr;

    assign first_c = pick_pat(4'(pat_mask), 3'd0);
    assign next_c  = pick_pat(4'(pat_mask), {1'b0, pat} + 3'd1);

    // Compare stage: a pending read completes on the next clock unless aborted.
    assign cmp_c  = cmp_pending && !abort;
    assign miss_c = cmp_c && (rdd != exp_q);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            addr  <= '0;
            pat   <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            pat   <= pat_nxt;
        end
    end

    // Next-state and control decode; abort outranks everything, enable=0 freezes.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        pat_nxt   = pat;
        clear_c   = 1'b0;
        empty_c   = 1'b0;
        wr_c      = 1'b0;
        rd_c      = 1'b0;
        finish_c  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
        end else if (enable) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        clear_c  = 1'b1;
                        addr_nxt = '0;
                        if (first_c[2]) begin
                            pat_nxt   = first_c[1:0];
                            state_nxt = WRITE;
                        end else begin
                            empty_c   = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
                WRITE: begin
                    wr_c     = 1'b1;
                    addr_nxt = addr + AW'(1);
                    if (addr == '1) state_nxt = READ;
                end
                READ: begin
                    rd_c     = 1'b1;
                    addr_nxt = addr + AW'(1);
                    if (addr == '1) state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (next_c[2]) begin
                        pat_nxt   = next_c[1:0];
                        state_nxt = WRITE;
                    end else begin
                        finish_c  = 1'b1;
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Memory ports, compare pipeline, counters and status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we          <= 1'b0;
            wra         <= '0;
            wrd         <= '0;
            exp_q       <= '0;
            cmp_pending <= 1'b0;
            any_fail    <= 1'b0;
            attempts    <= '0;
            fails       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            we          <= wr_c;
            cmp_pending <= rd_c;
            if (wr_c) begin
                wra <= addr;
                wrd <= expected_c;
            end
            if (rd_c) exp_q <= expected_c;
            if (clear_c) begin
                attempts <= '0;
                fails    <= '0;
                any_fail <= 1'b0;
                busy     <= !empty_c;
                done     <= empty_c;
                pass     <= empty_c;
            end else begin
                for (int p = 0; p < NPAT; p++) begin
                    if (cmp_c && (pat == PW'(p))) begin
                        attempts[p*CW +: CW] <= attempts[p*CW +: CW] + CW'(1);
                        if (miss_c) fails[p*CW +: CW] <= fails[p*CW +: CW] + CW'(1);
                    end
                end
                if (miss_c) any_fail <= 1'b1;
                if (abort) begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    pass <= 1'b0;
                end else if (finish_c) begin
                    // The last compare lands on this same edge, so fold it in here.
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= !(any_fail || miss_c);
                end
            end
        end
    end

`ifdef MBT_FIRST_FAIL_EN
    logic [AW-1:0] cmp_addr;

    // First-fail capture; later mismatches leave the record untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmp_addr <= '0;
            ff_valid <= 1'b0;
            ff_pat   <= '0;
            ff_addr  <= '0;
            ff_data  <= '0;
        end else begin
            if (rd_c) cmp_addr <= addr;
            if (clear_c) begin
                ff_valid <= 1'b0;
                ff_pat   <= '0;
                ff_addr  <= '0;
                ff_data  <= '0;
            end else if (miss_c && !ff_valid) begin
                ff_valid <= 1'b1;
                ff_pat   <= pat;
                ff_addr  <= cmp_addr;
                ff_data  <= rdd;
            end
        end
    end
`else
    assign ff_valid = 1'b0;
    assign ff_pat   = '0;
    assign ff_addr  = '0;
    assign ff_data  = '0;
`endif

endmodule

// File: tb/tb_mem_bist_tester.sv
// Self-checking bench for mem_bist_tester with a behavioural 1R1W memory
// (registered read, optional stuck-at-1 on bit 3 of address 8'h2A).
module tb_mem_bist_tester;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned NPAT = 4;
    localparam int unsigned CW   = 9;

    logic              clock, reset, enable, start, abort;
    logic [NPAT-1:0]   pat_mask;
    logic              we;
    logic [AW-1:0]     wra, rda;
    logic [DW-1:0]     wrd, rdd;
    logic              busy, done, pass;
    logic [NPAT*CW-1:0] attempts, fails;
    logic              ff_valid;
    logic [1:0]        ff_pat;
    logic [AW-1:0]     ff_addr;
    logic [DW-1:0]     ff_data;

    mem_bist_tester #(.AW(AW), .DW(DW), .NPAT(NPAT), .CW(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .abort    (abort),
        .pat_mask (pat_mask),
        .we       (we),
        .wra      (wra),
        .wrd      (wrd),
        .rda      (rda),
        .rdd      (rdd),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .attempts (attempts),
        .fails    (fails),
        .ff_valid (ff_valid),
        .ff_pat   (ff_pat),
        .ff_addr  (ff_addr),
        .ff_data  (ff_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model
    logic [DW-1:0] mem [0:255];
    bit            fault_en;
    always @(posedge clock) begin
        if (we) mem[wra] <= wrd;
        rdd <= mem[rda] | ((fault_en && rda == 8'h2A) ? 8'h08 : 8'h00);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input int p, input logic [7:0] a);
        case (p)
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return a[0] ? 8'hAA : 8'h55;
            default: return a;
        endcase
    endfunction

    // Write-port scoreboard: expected writes queued at start, popped as they appear.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t wq[$];
    wr_t wr_e;
    int  wr_err;

    always @(negedge clock) begin
        if (we === 1'b1) begin
            if (wq.size() == 0) wr_err++;
            else begin
                wr_e = wq.pop_front();
                if (wra !== wr_e.a || wrd !== wr_e.d) wr_err++;
            end
        end
    end

    typedef struct {
        logic [3:0]      mask;
        bit              fault;
        bit              tog;
        logic [3:0][8:0] att;
        logic [3:0][8:0] fl;
        logic            pass;
        logic            ffv;
        logic [1:0]      ffp;
        logic [7:0]      ffa;
        logic [7:0]      ffd;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] m, input bit f, input bit t,
                                input logic [3:0] fb, input logic ffv,
                                input logic [1:0] ffp, input logic [7:0] ffd);
        vec_t v;
        v.mask  = m;
        v.fault = f;
        v.tog   = t;
        for (int p = 0; p < 4; p++) begin
            v.att[p] = m[p] ? 9'd256 : 9'd0;
            v.fl[p]  = fb[p] ? 9'd1 : 9'd0;
        end
        v.pass = (fb == 4'b0000);
        v.ffv  = ffv;
        v.ffp  = ffp;
        v.ffa  = ffv ? 8'h2A : 8'h00;
        v.ffd  = ffd;
        return v;
    endfunction

    task automatic start_run(input logic [3:0] m, input bit f);
        wr_t e;
        @(negedge clock);
        wq.delete();
        wr_err   = 0;
        fault_en = f;
        for (int p = 0; p < 4; p++) begin
            if (m[p]) begin
                for (int a = 0; a < 256; a++) begin
                    e.a = 8'(a);
                    e.d = model(p, 8'(a));
                    wq.push_back(e);
                end
            end
        end
        pat_mask = m;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".we"}, we, 0);
        chk({tag, ".wra"}, wra, 0);
        chk({tag, ".wrd"}, wrd, 0);
        chk({tag, ".rda"}, rda, 0);
        chk({tag, ".attempts"}, attempts, 0);
        chk({tag, ".fails"}, fails, 0);
        chk({tag, ".ff_valid"}, ff_valid, 0);
        chk({tag, ".ff_pat"}, ff_pat, 0);
        chk({tag, ".ff_addr"}, ff_addr, 0);
        chk({tag, ".ff_data"}, ff_data, 0);
    endtask

    // n counts enabled edges since start; n%513 in 257..510 is safely inside READ.
    task automatic run_vec(input vec_t v, input int id);
        int    cyc, n, ph, stalls, we_bad;
        bit    fin;
        string tag;
        tag = $sformatf("v%0d", id);
        start_run(v.mask, v.fault);
        cyc = 0; n = 0; ph = 0; stalls = 0; we_bad = 0;
        fin = (done === 1'b1);
        while (!fin && cyc < 6000) begin
            @(negedge clock);
            if (v.tog && (n % 513) >= 257 && (n % 513) <= 510) begin
                enable = (ph < 3);
                ph = (ph + 1) % 6;
            end else begin
                enable = 1'b1;
            end
            if (!enable && we !== 1'b0) we_bad++;
            @(posedge clock);
            cyc++;
            if (enable) n++;
            else stalls++;
            #1;
            fin = (done === 1'b1);
        end
        enable = 1'b1;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".cycles"}, cyc, 513 * $countones(v.mask) + stalls);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("%s.attempts%0d", tag, p), attempts[p*CW +: CW], v.att[p]);
            chk($sformatf("%s.fails%0d", tag, p), fails[p*CW +: CW], v.fl[p]);
        end
        chk({tag, ".pass"}, pass, v.pass);
        chk({tag, ".wr_err"}, wr_err, 0);
        chk({tag, ".wr_left"}, wq.size(), 0);
        if (v.tog) begin
            chk({tag, ".stalled"}, stalls != 0, 1);
            chk({tag, ".we_stall"}, we_bad, 0);
        end
`ifdef MBT_FIRST_FAIL_EN
        chk({tag, ".ff_valid"}, ff_valid, v.ffv);
        chk({tag, ".ff_pat"}, ff_pat, v.ffp);
        chk({tag, ".ff_addr"}, ff_addr, v.ffa);
        chk({tag, ".ff_data"}, ff_data, v.ffd);
`else
        chk({tag, ".ff_valid"}, ff_valid, 0);
        chk({tag, ".ff_data"}, ff_data, 0);
`endif
    endtask

    vec_t vecs[9];

    initial begin
        int k;
        vecs[0] = mk(4'b1111, 0, 0, 4'b0000, 0, 2'd0, 8'h00);
        vecs[1] = mk(4'b0001, 1, 0, 4'b0001, 1, 2'd0, 8'h08);
        vecs[2] = mk(4'b0100, 0, 0, 4'b0000, 0, 2'd0, 8'h00);
        vecs[3] = mk(4'b1111, 0, 1, 4'b0000, 0, 2'd0, 8'h00);
        vecs[4] = mk(4'b0000, 0, 0, 4'b0000, 0, 2'd0, 8'h00);
        vecs[5] = mk(4'b1100, 1, 0, 4'b0100, 1, 2'd2, 8'h5D);
        vecs[6] = mk(4'b1111, 1, 0, 4'b0101, 1, 2'd0, 8'h08);
        vecs[7] = mk(4'b1010, 1, 0, 4'b0000, 0, 2'd0, 8'h00);
        vecs[8] = mk(4'b0001, 1, 1, 4'b0001, 1, 2'd0, 8'h08);

        reset    = 1'b0;
        enable   = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        pat_mask = '0;
        fault_en = 0;
        wr_err   = 0;
        #12;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Abort while writing address 100, then a normal run.
        start_run(4'b1111, 0);
        k = 0;
        while (!(we === 1'b1 && wra === 8'd100) && k < 600) begin
            @(negedge clock);
            k++;
        end
        chk("abort.reach", (we === 1'b1 && wra === 8'd100), 1);
        abort = 1'b1;
        @(posedge clock);
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.we", we, 0);
        chk("abort.attempts", attempts, 0);
        @(negedge clock);
        abort = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort.idle_busy", busy, 0);
        chk("abort.idle_we", we, 0);
        run_vec(vecs[0], 20);

        // Asynchronous reset in the middle of the read pass.
        start_run(4'b0001, 1);
        repeat (310) @(posedge clock);
        #1;
        chk("mid.fails0", fails[CW-1:0], 1);
        chk("mid.busy", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clock);
        reset = 1'b1;
        run_vec(vecs[1], 21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
